// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO: issues read enables and turns the
// FIFO's 1-cycle registered read data into a valid/ready stream with a 2-entry buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  idle
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic [2:0]            credit_used;

  // Handshake: a word transfers only when m_valid & m_ready at a posedge;
  // while m_valid & !m_ready the producer holds m_valid and m_data unchanged.
  assign pop = m_valid & m_ready;

  // Buffer slots committed after this edge: held words plus the word in flight,
  // minus the one leaving. A new read is issued only if a slot stays free.
  assign credit_used = 3'(occ) + {2'b00, inflight} - {2'b00, pop};
  assign fifo_r_en   = !rst & en & !fifo_empty & (credit_used < 3'd2);

  assign idle = (occ == EMPTY) & !inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      tail     <= '0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_r_en;

      // m_data is the head entry; tail holds the second word when two are buffered.
      case (occ)
        EMPTY: begin
          if (inflight) begin
            occ     <= ONE;
            m_valid <= 1'b1;
            m_data  <= fifo_data;
          end
        end
        ONE: begin
          if (inflight && !pop) begin
            occ  <= TWO;
            tail <= fifo_data;
          end else if (inflight && pop) begin
            m_data <= fifo_data;
          end else if (pop) begin
            occ     <= EMPTY;
            m_valid <= 1'b0;
          end
        end
        TWO: begin
          // The credit rule guarantees no capture can arrive while full.
          if (pop) begin
            occ    <= ONE;
            m_data <= tail;
          end
        end
        default: begin
          occ     <= EMPTY;
          m_valid <= 1'b0;
        end
      endcase

      if (cnt_clr) begin
        word_cnt <= pop ? CNT_WIDTH'(1) : '0;
      end else if (pop) begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
